// File: rtl/tc_psum_drain.sv
// Purpose: snapshots one M*N result matrix from the accumulator (optional ReLU) and streams it out row by row.
// Latency: first row beat 1 clk after capture; M beats back-to-back; done pulses 1 clk after the last handshake.
// Backpressure: out_ready=0 holds the current beat stable; in_ready stays low until the whole frame has drained.
module tc_psum_drain #(
  parameter int M       = 16,
  parameter int N       = 16,
  parameter int DW_DATA = 8,
  parameter int DW_ROW  = 4,
  parameter int DW_IN   = M * N * DW_DATA,
  parameter int DW_LINE = N * DW_DATA
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW_IN-1:0]   in,
  input  logic               relu_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW_LINE-1:0] out_data,
  output logic [DW_ROW-1:0]  out_row,
  output logic               out_last,
  output logic               done
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state;
  logic [DW_ROW-1:0]  row_cnt;
  logic [DW_IN-1:0]   snap;
  logic [DW_IN-1:0]   cap_dat;

  // ReLU clamp applied on the way into the snapshot: negative elements become zero.
  always_comb begin
    cap_dat = in;
    if (relu_en) begin
      for (int i = 0; i < M * N; i++) begin
        if (in[i*DW_DATA + DW_DATA - 1]) begin
          cap_dat[i*DW_DATA +: DW_DATA] = '0;
        end
      end
    end
  end

  // Row select from the snapshot; the row counter only changes on a handshake, so the beat is stable under stall.
  always_comb begin
    out_data = '0;
    for (int r = 0; r < M; r++) begin
      if (row_cnt == DW_ROW'(r)) begin
        out_data = snap[r*DW_LINE +: DW_LINE];
      end
    end
  end

  assign out_row = row_cnt;

  // Capture/stream FSM with registered handshake outputs; reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      row_cnt   <= '0;
      snap      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            snap      <= cap_dat;
            row_cnt   <= '0;
            state     <= SEND;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            out_last  <= (M == 1);
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              row_cnt   <= '0;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              row_cnt  <= row_cnt + 1'b1;
              out_last <= (row_cnt == DW_ROW'(M - 2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tc_psum_drain.sv
// Purpose: directed scoreboard bench for tc_psum_drain at M=4, N=4, 8-bit elements.
// Latency: stimulus pushes expected row beats; a negedge monitor pops and compares on each handshake.
// Backpressure: exercised by stalling out_ready mid-frame and by offering a matrix while busy.
module tb_tc_psum_drain;

  localparam int M = 4;
  localparam int N = 4;
  localparam int DW_DATA = 8;
  localparam int DW_ROW = 4;
  localparam int DW_IN = M * N * DW_DATA;
  localparam int DW_LINE = N * DW_DATA;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [DW_IN-1:0]   in;
  logic               relu_en;
  logic               out_valid;
  logic               out_ready;
  logic [DW_LINE-1:0] out_data;
  logic [DW_ROW-1:0]  out_row;
  logic               out_last;
  logic               done;

  typedef struct packed {
    logic [DW_LINE-1:0] data;
    logic [DW_ROW-1:0]  row;
    logic               last;
  } beat_t;

  beat_t exp_q[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    vld_cnt = 0;
  logic  exp_done = 1'b0;

  always #5 clk = ~clk;

  tc_psum_drain #(
    .M(M), .N(N), .DW_DATA(DW_DATA), .DW_ROW(DW_ROW), .DW_IN(DW_IN), .DW_LINE(DW_LINE)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .done(done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [DW_IN-1:0] seq_mat(input int base);
    logic [DW_IN-1:0] m;
    m = '0;
    for (int i = 0; i < M * N; i++) m[i*DW_DATA +: DW_DATA] = 8'(base + i);
    return m;
  endfunction

  function automatic logic [DW_LINE-1:0] exp_row(input logic [DW_IN-1:0] m, input logic relu, input int r);
    logic [DW_LINE-1:0] row;
    logic [DW_DATA-1:0] e;
    for (int c = 0; c < N; c++) begin
      e = m[(r*N + c)*DW_DATA +: DW_DATA];
      row[c*DW_DATA +: DW_DATA] = (relu && e[DW_DATA-1]) ? '0 : e;
    end
    return row;
  endfunction

  task automatic push_frame(input logic [DW_IN-1:0] m, input logic relu);
    for (int r = 0; r < M; r++) exp_q.push_back({exp_row(m, relu, r), DW_ROW'(r), (r == M - 1)});
  endtask

  // Offer a matrix until the drain takes it; returns 1 clk after the capture edge.
  task automatic send_frame(input logic [DW_IN-1:0] m, input logic relu);
    logic took;
    took = 1'b0;
    push_frame(m, relu);
    in = m;
    relu_en = relu;
    in_valid = 1'b1;
    for (int i = 0; i < 30 && !took; i++) begin
      smp();
      took = in_ready;
      step();
    end
    in_valid = 1'b0;
    chk("capture_accepted", took, 1'b1);
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      smp();
      seen = done;
    end
    chk("done_seen", seen, 1'b1);
    step();
  endtask

  // Scoreboard monitor: pops one expected beat per handshake, and checks done pulses exactly after the last one.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      if (exp_done) chk("done_pulse", done, 1'b1);
      else if (done) chk("done_spurious", done, 1'b0);
      if (out_valid) vld_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", out_data, e.data);
          chk("beat_row", out_row, e.row);
          chk("beat_last", out_last, e.last);
        end
      end
      exp_done = out_valid && out_ready && out_last;
    end else begin
      exp_done = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW_IN-1:0] ma;
    logic [DW_IN-1:0] mb;
    logic [DW_IN-1:0] mr;
    logic             seen;

    rst = 1'b0; in_valid = 1'b0; in = '0; relu_en = 1'b0; out_ready = 1'b1;

    // Reset state
    step(); step();
    smp();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_row", out_row, 4'd0);
    chk("rst_done", done, 1'b0);
    step();
    rst = 1'b1;

    // Basic frame: element (r,c) = r*4+c, full throughput
    vld_cnt = 0;
    send_frame(seq_mat(0), 1'b0);
    smp();
    chk("lat_first_valid", out_valid, 1'b1);
    chk("lat_first_row", out_row, 4'd0);
    chk("busy_in_ready", in_ready, 1'b0);
    step();
    smp();
    chk("row1_data", out_data, 32'h07060504);
    step(); step();
    smp();
    chk("row3_last", out_last, 1'b1);
    wait_done();
    chk("frame_cycles_full", vld_cnt, 4);
    chk("idle_out_valid", out_valid, 1'b0);

    // ReLU on and off with a negative and a positive element
    mr = '0;
    mr[7:0] = 8'hF0;
    mr[15:8] = 8'h7F;
    send_frame(mr, 1'b1);
    smp();
    chk("relu_on_row0", out_data, 32'h00007F00);
    wait_done();
    send_frame(mr, 1'b0);
    smp();
    chk("relu_off_row0", out_data, 32'h00007FF0);
    wait_done();

    // Backpressure: stall 3 cycles on row 2
    vld_cnt = 0;
    send_frame(seq_mat(16), 1'b0);
    step(); step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_row", out_row, 4'd2);
      chk("stall_data", out_data, 32'h1B1A1918);
      chk("stall_last", out_last, 1'b0);
      step();
    end
    out_ready = 1'b1;
    step();
    smp();
    chk("after_stall_row", out_row, 4'd3);
    chk("after_stall_last", out_last, 1'b1);
    wait_done();
    chk("frame_cycles_stall", vld_cnt, 7);

    // Busy upstream: second matrix offered during SEND, taken in the done cycle
    ma = seq_mat(40);
    mb = seq_mat(80);
    send_frame(ma, 1'b0);
    push_frame(mb, 1'b0);
    in = mb;
    in_valid = 1'b1;
    smp();
    chk("busy_in_ready2", in_ready, 1'b0);
    chk("busy_row0_unchanged", out_data, 32'h2B2A2928);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      smp();
      seen = done;
      if (seen) chk("done_cycle_in_ready", in_ready, 1'b1);
      step();
    end
    chk("busy_done_seen", seen, 1'b1);
    in_valid = 1'b0;
    smp();
    chk("next_frame_valid", out_valid, 1'b1);
    chk("next_frame_row", out_row, 4'd0);
    chk("next_frame_data", out_data, 32'h53525150);
    wait_done();

    // Mid-frame reset after the row-1 handshake
    send_frame(seq_mat(100), 1'b0);
    step(); step();
    rst = 1'b0;
    out_ready = 1'b0;
    step();
    smp();
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_out_row", out_row, 4'd0);
    chk("mid_rst_pending", exp_q.size(), 2);
    exp_q.delete();
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      smp();
      chk("post_rst_quiet", out_valid, 1'b0);
    end
    step();

    // Input stability: `in` changes every cycle while the captured frame drains
    send_frame(seq_mat(150), 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      in = {$urandom, $urandom, $urandom, $urandom};
      smp();
      seen = done;
      step();
    end
    chk("stable_done_seen", seen, 1'b1);

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tc_psum_drain.md
Name: tc_psum_drain

Overview:
- Downstream of the partial-sum accumulator. Captures one complete M*N result matrix, presented flat when the accumulator asserts its output-valid, into a local snapshot buffer.
- Streams the snapshot out one row (N elements) per beat over a valid/ready handshake, with optional ReLU applied at capture.
- Frees the accumulator for the next tile as soon as the capture is done.
- Sits between the accumulator and the writeback/output interface.

Parameters:
- M, 16, rows of result matrix (>=1)
- N, 16, columns of result matrix (>=1)
- DW_DATA, 8, element width, two's complement
- DW_ROW, 4, row-index width; 2^DW_ROW >= M
- DW_IN, M*N*DW_DATA, flat matrix input width
- DW_LINE, N*DW_DATA, output row width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
- in_valid  in  1  matrix on `in` is valid (driven by accumulator out_valid)
- in_ready  out  1  drain can accept a matrix this cycle
- in  in  DW_IN  flat matrix; element (r,c) at bits [(r*N+c)*DW_DATA +: DW_DATA]
- relu_en  in  1  sampled with the matrix; 1 = clamp negative elements to 0
- out_valid  out  1  row beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  DW_LINE  row; element c at bits [c*DW_DATA +: DW_DATA]
- out_row  out  DW_ROW  row index of current beat
- out_last  out  1  current beat is row M-1
- done  out  1  one-cycle pulse after the last row handshake

Behaviour:
- FSM states: IDLE, SEND.
- Reset (rst=0 at a clock edge):
  - state=IDLE, row counter=0.
  - Outputs: in_ready=1, out_valid=0, out_last=0, out_row=0, done=0.
  - Snapshot buffer cleared to 0.
  - Reset overrides every other event, including mid-SEND. The partial frame is discarded and never resumed.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1 the matrix is captured into the snapshot (one cycle) and state goes to SEND. Element rule: relu_en=1 and element MSB=1 -> store 0; otherwise store the value unchanged. relu_en is latched at the same edge.
  - Row counter is set to 0.
  - in_valid=0 -> remain in IDLE.
- SEND:
  - in_ready=0. in_valid is ignored; the upstream holds its data or retries later.
  - out_valid=1 from the first cycle after capture (capture-to-first-beat latency = 1 clk).
  - out_data = snapshot row[row counter], out_row = row counter, out_last = (row counter == M-1).
  - out_ready=0 -> all outputs held stable, with no change in data, row or last (AXI-style; valid never drops without a handshake).
  - Handshake (out_valid & out_ready) with out_last=0 -> row counter+1, next row presented next cycle. Back-to-back beats are allowed, so M rows take M cycles at full throughput.
  - Handshake with out_last=1 -> state=IDLE, row counter=0, done=1 for exactly the next cycle.
  - out_valid=0 and in_ready=1 in that same cycle. A new matrix may be captured in that cycle, so there is 1 idle cycle between frames.
- M=1: the first beat has out_last=1.
- Snapshot is written only at capture. Later changes on `in` do not affect beats in flight.
- No arithmetic beyond the ReLU clamp. Element width is preserved with no saturation or truncation.
- out_row is zero-extended to DW_ROW.

Test Plan:
- Reset then capture: rst=0 for 2 clks, then rst=1 -> in_ready=1, out_valid=0. Drive in_valid=1 for 1 clk with M=4, N=4, element (r,c)=r*4+c, relu_en=0, out_ready=1 held -> beats on 4 consecutive cycles starting 1 clk after capture. out_data row1 = {7,6,5,4} (MSB-first), out_row 0..3, out_last only on row 3, done pulses the cycle after row 3.
- ReLU: element (0,0)=8'hF0, element (0,1)=8'h7F, relu_en=1 -> row0 elements 0 and 1 read 8'h00 and 8'h7F. Same data with relu_en=0 -> 8'hF0 and 8'h7F.
- Backpressure: out_ready=0 for 3 clks on row 2 -> out_data, out_row=2 and out_last held constant, out_valid stays 1. Release -> row 3 follows next cycle; total frame = 4+3 cycles.
- Busy upstream: assert in_valid with a different matrix during SEND -> in_ready=0 and the current frame data is unchanged. That matrix is captured in the cycle done=1, and its row0 appears 1 clk later.
- Mid-frame reset: rst=0 after the row-1 handshake -> next cycle out_valid=0, in_ready=1, done=0, out_row=0. No further beats from the old frame.
- Input stability: change `in` every cycle during SEND -> all beats match the matrix captured at the accept edge.
